// File: rtl/mcpu_core_refill_arb_pkg.sv
// Shared definitions for the core refill arbiter.
// Holds the arbiter FSM state encoding, the requester identifiers and the default
// line/beat geometry used by mcpu_core_refill_arb and mcpu_core_rr_arb2.
package mcpu_core_refill_arb_pkg;

    // Default geometry: 16-byte lines, 4 x 32-bit beats per line.
    localparam int unsigned ADDR_W_DEF = 28;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned BEATS_DEF  = 4;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StRburst,
        StWburst,
        StDone
    } arb_state_e;

    typedef enum logic {
        REQ_IC = 1'b0,
        REQ_DC = 1'b1
    } req_id_e;

endpackage

// File: rtl/mcpu_core_rr_arb2.sv
// Two-input round-robin arbiter for the refill arbiter.
// Ports:
//   clkrst_core_clk  clock
//   clkrst_core_rst  asynchronous active-high reset
//   req_ic, req_dc   requests from the I$ and D$
//   grant_en         the caller takes the grant this cycle; updates last_grant
//   grant_valid      at least one request is high
//   grant_id         requester that wins this cycle
module mcpu_core_rr_arb2
    import mcpu_core_refill_arb_pkg::*;
(
    input  logic    clkrst_core_clk,
    input  logic    clkrst_core_rst,
    input  logic    req_ic,
    input  logic    req_dc,
    input  logic    grant_en,
    output logic    grant_valid,
    output req_id_e grant_id
);

    req_id_e last_grant_q;

    // Resetting to D$ makes the first tie after reset go to the I$.
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            last_grant_q <= REQ_DC;
        end else if (grant_en && grant_valid) begin
            last_grant_q <= grant_id;
        end
    end

    always_comb begin
        grant_valid = req_ic | req_dc;
        grant_id    = REQ_DC;
        if (req_ic && req_dc) begin
            grant_id = (last_grant_q == REQ_DC) ? REQ_IC : REQ_DC;
        end else if (req_ic) begin
            grant_id = REQ_IC;
        end
    end

endmodule

// File: rtl/mcpu_core_refill_arb.sv
// Core refill arbiter: shares the single memory port between I$ line fills and
// D$ fills/writebacks. Each transaction runs command -> burst -> done, with
// round-robin fairness between the two caches.
// Ports:
//   clkrst_core_clk / clkrst_core_rst   clock, asynchronous active-high reset
//   ic2arb_*  / arb2ic_*                I$ request, cancel, fill data and done
//   dc2arb_*  / arb2dc_*                D$ request, writeback data, fill data, done
//   arb2mem_* / mem2arb_*               memory command, write beats and read beats
module mcpu_core_refill_arb
    import mcpu_core_refill_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned BEATS  = BEATS_DEF
) (
    input  logic              clkrst_core_clk,
    input  logic              clkrst_core_rst,
    // I$ side
    input  logic              ic2arb_req,
    input  logic [ADDR_W-1:0] ic2arb_addr,
    input  logic              ic2arb_cancel,
    output logic [DATA_W-1:0] arb2ic_rdata,
    output logic              arb2ic_rvalid,
    output logic              arb2ic_done,
    // D$ side
    input  logic              dc2arb_req,
    input  logic              dc2arb_we,
    input  logic [ADDR_W-1:0] dc2arb_addr,
    input  logic [DATA_W-1:0] dc2arb_wdata,
    output logic              arb2dc_wready,
    output logic [DATA_W-1:0] arb2dc_rdata,
    output logic              arb2dc_rvalid,
    output logic              arb2dc_done,
    // memory side
    output logic              arb2mem_valid,
    output logic              arb2mem_we,
    output logic [ADDR_W-1:0] arb2mem_addr,
    input  logic              mem2arb_ready,
    output logic [DATA_W-1:0] arb2mem_wdata,
    input  logic              mem2arb_wready,
    input  logic [DATA_W-1:0] mem2arb_rdata,
    input  logic              mem2arb_rvalid
);

    localparam int unsigned CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

    arb_state_e        state_q, state_d;
    req_id_e           gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;

    logic    grant_en;
    logic    grant_valid;
    req_id_e grant_id;
    logic    cnt_last;
    logic    cancel_hit;
    logic    ic_drop;

    assign grant_en = (state_q == StIdle);
    assign cnt_last = (cnt_q == CNT_LAST);

    // A cancel only matters while the I$ owns the port and beats are still to come.
    assign cancel_hit = ic2arb_cancel && (gnt_q == REQ_IC) &&
                        ((state_q == StCmd) || (state_q == StRburst));
    // Suppress the beat arriving in the same cycle as the cancel as well.
    assign ic_drop = drop_q | cancel_hit;

    mcpu_core_rr_arb2 u_rr_arb2 (
        .clkrst_core_clk (clkrst_core_clk),
        .clkrst_core_rst (clkrst_core_rst),
        .req_ic          (ic2arb_req),
        .req_dc          (dc2arb_req),
        .grant_en        (grant_en),
        .grant_valid     (grant_valid),
        .grant_id        (grant_id)
    );

    // State register
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Transaction context registers
    always_ff @(posedge clkrst_core_clk or posedge clkrst_core_rst) begin
        if (clkrst_core_rst) begin
            gnt_q  <= REQ_DC;
            we_q   <= 1'b0;
            addr_q <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            gnt_q  <= gnt_d;
            we_q   <= we_d;
            addr_q <= addr_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (grant_valid) state_d = StCmd;
            StCmd:    if (mem2arb_ready) state_d = we_q ? StWburst : StRburst;
            StRburst: if (mem2arb_rvalid && cnt_last) state_d = StDone;
            StWburst: if (mem2arb_wready && cnt_last) state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Context capture at grant, beat counting and the sticky cancel flag
    always_comb begin
        gnt_d  = gnt_q;
        we_d   = we_q;
        addr_d = addr_q;
        cnt_d  = cnt_q;
        drop_d = drop_q;
        unique case (state_q)
            StIdle: begin
                if (grant_valid) begin
                    gnt_d = grant_id;
                    cnt_d = '0;
                    if (grant_id == REQ_IC) begin
                        we_d   = 1'b0;
                        addr_d = ic2arb_addr;
                    end else begin
                        we_d   = dc2arb_we;
                        addr_d = dc2arb_addr;
                    end
                end
            end
            StRburst: if (mem2arb_rvalid) cnt_d = cnt_q + CNT_W'(1);
            StWburst: if (mem2arb_wready) cnt_d = cnt_q + CNT_W'(1);
            StDone:   drop_d = 1'b0;
            default:  ;
        endcase
        if (cancel_hit) begin
            drop_d = 1'b1;
        end
    end

    // Output logic
    always_comb begin
        arb2mem_valid = 1'b0;
        arb2mem_we    = 1'b0;
        arb2mem_addr  = addr_q;
        arb2mem_wdata = '0;
        arb2ic_rdata  = '0;
        arb2ic_rvalid = 1'b0;
        arb2ic_done   = 1'b0;
        arb2dc_wready = 1'b0;
        arb2dc_rdata  = '0;
        arb2dc_rvalid = 1'b0;
        arb2dc_done   = 1'b0;
        unique case (state_q)
            StCmd: begin
                arb2mem_valid = 1'b1;
                arb2mem_we    = we_q;
            end
            StRburst: begin
                if (mem2arb_rvalid) begin
                    if (gnt_q == REQ_IC) begin
                        if (!ic_drop) begin
                            arb2ic_rvalid = 1'b1;
                            arb2ic_rdata  = mem2arb_rdata;
                        end
                    end else begin
                        arb2dc_rvalid = 1'b1;
                        arb2dc_rdata  = mem2arb_rdata;
                    end
                end
            end
            StWburst: begin
                // Only the D$ ever writes, so the beat path is direct.
                arb2mem_wdata = dc2arb_wdata;
                arb2dc_wready = mem2arb_wready;
            end
            StDone: begin
                arb2ic_done = (gnt_q == REQ_IC) && !drop_q;
                arb2dc_done = (gnt_q == REQ_DC);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mcpu_core_refill_arb.sv
// Directed self-checking bench for mcpu_core_refill_arb.
// Inputs are driven on the falling edge and outputs sampled 1 ns later.
module tb_mcpu_core_refill_arb;

    logic        clkrst_core_clk;
    logic        clkrst_core_rst;
    logic        ic2arb_req;
    logic [27:0] ic2arb_addr;
    logic        ic2arb_cancel;
    logic [31:0] arb2ic_rdata;
    logic        arb2ic_rvalid;
    logic        arb2ic_done;
    logic        dc2arb_req;
    logic        dc2arb_we;
    logic [27:0] dc2arb_addr;
    logic [31:0] dc2arb_wdata;
    logic        arb2dc_wready;
    logic [31:0] arb2dc_rdata;
    logic        arb2dc_rvalid;
    logic        arb2dc_done;
    logic        arb2mem_valid;
    logic        arb2mem_we;
    logic [27:0] arb2mem_addr;
    logic        mem2arb_ready;
    logic [31:0] arb2mem_wdata;
    logic        mem2arb_wready;
    logic [31:0] mem2arb_rdata;
    logic        mem2arb_rvalid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [130:0] all_out;
    assign all_out = {arb2mem_valid, arb2mem_we, arb2mem_addr, arb2mem_wdata,
                      arb2ic_rvalid, arb2ic_rdata, arb2ic_done,
                      arb2dc_wready, arb2dc_rvalid, arb2dc_rdata, arb2dc_done};

    mcpu_core_refill_arb #(
        .ADDR_W (28),
        .DATA_W (32),
        .BEATS  (4)
    ) dut (
        .clkrst_core_clk (clkrst_core_clk),
        .clkrst_core_rst (clkrst_core_rst),
        .ic2arb_req      (ic2arb_req),
        .ic2arb_addr     (ic2arb_addr),
        .ic2arb_cancel   (ic2arb_cancel),
        .arb2ic_rdata    (arb2ic_rdata),
        .arb2ic_rvalid   (arb2ic_rvalid),
        .arb2ic_done     (arb2ic_done),
        .dc2arb_req      (dc2arb_req),
        .dc2arb_we       (dc2arb_we),
        .dc2arb_addr     (dc2arb_addr),
        .dc2arb_wdata    (dc2arb_wdata),
        .arb2dc_wready   (arb2dc_wready),
        .arb2dc_rdata    (arb2dc_rdata),
        .arb2dc_rvalid   (arb2dc_rvalid),
        .arb2dc_done     (arb2dc_done),
        .arb2mem_valid   (arb2mem_valid),
        .arb2mem_we      (arb2mem_we),
        .arb2mem_addr    (arb2mem_addr),
        .mem2arb_ready   (mem2arb_ready),
        .arb2mem_wdata   (arb2mem_wdata),
        .mem2arb_wready  (mem2arb_wready),
        .mem2arb_rdata   (mem2arb_rdata),
        .mem2arb_rvalid  (mem2arb_rvalid)
    );

    initial begin
        clkrst_core_clk = 1'b0;
        forever #5 clkrst_core_clk = ~clkrst_core_clk;
    end

    task automatic clear_inputs();
        ic2arb_req = 0; ic2arb_addr = '0; ic2arb_cancel = 0;
        dc2arb_req = 0; dc2arb_we = 0; dc2arb_addr = '0; dc2arb_wdata = '0;
        mem2arb_ready = 0; mem2arb_wready = 0; mem2arb_rdata = '0; mem2arb_rvalid = 0;
    endtask

    task automatic do_reset();
        @(negedge clkrst_core_clk);
        clear_inputs();
        clkrst_core_rst = 1;
        @(negedge clkrst_core_clk);
        clkrst_core_rst = 0;
    endtask

    task automatic test_reset();
        @(negedge clkrst_core_clk);
        clkrst_core_rst = 1;
        ic2arb_req = 1; dc2arb_req = 1; mem2arb_ready = 1;
        mem2arb_rvalid = 1; mem2arb_wready = 1; mem2arb_rdata = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        @(negedge clkrst_core_clk); #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL reset_held: got %h want 0", all_out);
        end
        clear_inputs();
        clkrst_core_rst = 0;
        #1;
        n_checks++;
        if (arb2mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release_valid: got %b want 0", arb2mem_valid);
        end
    endtask

    task automatic test_ic_fill();
        logic [31:0] exp;
        @(negedge clkrst_core_clk);
        ic2arb_req = 1; ic2arb_addr = 28'h0001234;
        #1;
        n_checks++;
        if (arb2mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL ic_fill_latency: valid=%b want 0", arb2mem_valid);
        end
        @(negedge clkrst_core_clk);
        mem2arb_ready = 1;
        #1;
        n_checks++;
        if ({arb2mem_valid, arb2mem_we, arb2mem_addr} !== {1'b1, 1'b0, 28'h0001234}) begin
            n_fail++;
            $display("FAIL ic_fill_cmd: valid=%b we=%b addr=%h want 1 0 0001234",
                     arb2mem_valid, arb2mem_we, arb2mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 32'hA0 + 32'(i);
            @(negedge clkrst_core_clk);
            mem2arb_ready = 0; mem2arb_rvalid = 1; mem2arb_rdata = exp;
            #1;
            n_checks++;
            if ({arb2ic_rvalid, arb2ic_rdata, arb2ic_done} !== {1'b1, exp, 1'b0}) begin
                n_fail++;
                $display("FAIL ic_fill_beat%0d: rvalid=%b rdata=%h done=%b want 1 %h 0",
                         i, arb2ic_rvalid, arb2ic_rdata, arb2ic_done, exp);
            end
            n_checks++;
            if ({arb2dc_wready, arb2dc_rvalid, arb2dc_rdata, arb2dc_done} !== '0) begin
                n_fail++;
                $display("FAIL ic_fill_dc_quiet%0d: dc rvalid=%b rdata=%h want 0",
                         i, arb2dc_rvalid, arb2dc_rdata);
            end
        end
        @(negedge clkrst_core_clk);
        mem2arb_rvalid = 0;
        #1;
        n_checks++;
        if ({arb2ic_done, arb2dc_done, arb2ic_rvalid} !== 3'b100) begin
            n_fail++;
            $display("FAIL ic_fill_done: ic_done=%b dc_done=%b rvalid=%b want 1 0 0",
                     arb2ic_done, arb2dc_done, arb2ic_rvalid);
        end
        ic2arb_req = 0;
        @(negedge clkrst_core_clk); #1;
        n_checks++;
        if ({arb2ic_done, arb2mem_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL ic_fill_after: done=%b valid=%b want 0 0", arb2ic_done, arb2mem_valid);
        end
    endtask

    task automatic test_tie_round_robin();
        logic [31:0] exp;
        do_reset();
        @(negedge clkrst_core_clk);
        ic2arb_req = 1; ic2arb_addr = 28'h0000200;
        dc2arb_req = 1; dc2arb_we = 0; dc2arb_addr = 28'h0000100;
        @(negedge clkrst_core_clk);
        mem2arb_ready = 1;
        #1;
        n_checks++;
        if ({arb2mem_valid, arb2mem_addr} !== {1'b1, 28'h0000200}) begin
            n_fail++;
            $display("FAIL tie1_ic_first: valid=%b addr=%h want 1 0000200",
                     arb2mem_valid, arb2mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clkrst_core_clk);
            mem2arb_ready = 0; mem2arb_rvalid = 1; mem2arb_rdata = 32'hB0 + 32'(i);
        end
        @(negedge clkrst_core_clk);
        mem2arb_rvalid = 0;
        // I$ immediately asks for another line so the next IDLE sees a tie.
        ic2arb_addr = 28'h0000210;
        #1;
        n_checks++;
        if (arb2ic_done !== 1'b1) begin
            n_fail++; $display("FAIL tie1_ic_done: got %b want 1", arb2ic_done);
        end
        @(negedge clkrst_core_clk); #1;
        n_checks++;
        if (arb2mem_valid !== 1'b0) begin
            n_fail++; $display("FAIL tie_idle_gap: valid=%b want 0", arb2mem_valid);
        end
        @(negedge clkrst_core_clk);
        mem2arb_ready = 1;
        #1;
        n_checks++;
        if ({arb2mem_valid, arb2mem_we, arb2mem_addr} !== {1'b1, 1'b0, 28'h0000100}) begin
            n_fail++;
            $display("FAIL tie2_dc_second: valid=%b we=%b addr=%h want 1 0 0000100",
                     arb2mem_valid, arb2mem_we, arb2mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 32'hC0 + 32'(i);
            @(negedge clkrst_core_clk);
            mem2arb_ready = 0; mem2arb_rvalid = 1; mem2arb_rdata = exp;
            #1;
            n_checks++;
            if ({arb2dc_rvalid, arb2dc_rdata, arb2ic_rvalid} !== {1'b1, exp, 1'b0}) begin
                n_fail++;
                $display("FAIL tie2_dc_beat%0d: dc_rvalid=%b rdata=%h ic_rvalid=%b want 1 %h 0",
                         i, arb2dc_rvalid, arb2dc_rdata, arb2ic_rvalid, exp);
            end
        end
        @(negedge clkrst_core_clk);
        mem2arb_rvalid = 0;
        #1;
        n_checks++;
        if ({arb2dc_done, arb2ic_done} !== 2'b10) begin
            n_fail++;
            $display("FAIL tie2_dc_done: dc=%b ic=%b want 1 0", arb2dc_done, arb2ic_done);
        end
        dc2arb_req = 0;
        @(negedge clkrst_core_clk);
        @(negedge clkrst_core_clk);
        mem2arb_ready = 1;
        #1;
        n_checks++;
        if ({arb2mem_valid, arb2mem_addr} !== {1'b1, 28'h0000210}) begin
            n_fail++;
            $display("FAIL tie3_ic_again: valid=%b addr=%h want 1 0000210",
                     arb2mem_valid, arb2mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clkrst_core_clk);
            mem2arb_ready = 0; mem2arb_rvalid = 1; mem2arb_rdata = 32'hD0 + 32'(i);
        end
        @(negedge clkrst_core_clk);
        mem2arb_rvalid = 0;
        ic2arb_req = 0;
        @(negedge clkrst_core_clk);
    endtask

    task automatic test_dc_writeback();
        logic [5:0] pat;
        int         pulses;
        logic [31:0] wd;
        pat = 6'b110101;
        pulses = 0;
        @(negedge clkrst_core_clk);
        dc2arb_req = 1; dc2arb_we = 1; dc2arb_addr = 28'h0000300; dc2arb_wdata = 32'h11;
        @(negedge clkrst_core_clk);
        mem2arb_ready = 1;
        #1;
        n_checks++;
        if ({arb2mem_valid, arb2mem_we, arb2mem_addr} !== {1'b1, 1'b1, 28'h0000300}) begin
            n_fail++;
            $display("FAIL wb_cmd: valid=%b we=%b addr=%h want 1 1 0000300",
                     arb2mem_valid, arb2mem_we, arb2mem_addr);
        end
        for (int i = 0; i < 6; i++) begin
            wd = 32'h11 + 32'(pulses);
            @(negedge clkrst_core_clk);
            mem2arb_ready = 0; dc2arb_wdata = wd; mem2arb_wready = pat[i];
            #1;
            n_checks++;
            if ({arb2dc_wready, arb2mem_wdata, arb2dc_done} !== {pat[i], wd, 1'b0}) begin
                n_fail++;
                $display("FAIL wb_beat%0d: wready=%b wdata=%h done=%b want %b %h 0",
                         i, arb2dc_wready, arb2mem_wdata, arb2dc_done, pat[i], wd);
            end
            if (arb2dc_wready === 1'b1) pulses++;
        end
        @(negedge clkrst_core_clk);
        mem2arb_wready = 1;
        #1;
        n_checks++;
        if ({arb2dc_done, arb2dc_wready} !== 2'b10) begin
            n_fail++;
            $display("FAIL wb_done: done=%b wready=%b want 1 0", arb2dc_done, arb2dc_wready);
        end
        n_checks++;
        if (pulses != 4) begin
            n_fail++; $display("FAIL wb_pulse_count: got %0d want 4", pulses);
        end
        clear_inputs();
        @(negedge clkrst_core_clk);
    endtask

    task automatic test_ic_cancel();
        int dc_beats;
        dc_beats = 0;
        @(negedge clkrst_core_clk);
        ic2arb_req = 1; ic2arb_addr = 28'h0000400;
        dc2arb_req = 1; dc2arb_we = 0; dc2arb_addr = 28'h0000500;
        @(negedge clkrst_core_clk);
        mem2arb_ready = 1;
        #1;
        n_checks++;
        if (arb2mem_addr !== 28'h0000400) begin
            n_fail++; $display("FAIL cancel_grant_ic: addr=%h want 0000400", arb2mem_addr);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clkrst_core_clk);
            mem2arb_ready = 0; mem2arb_rvalid = 1; mem2arb_rdata = 32'hE0 + 32'(i);
            #1;
            n_checks++;
            if (arb2ic_rvalid !== 1'b1) begin
                n_fail++; $display("FAIL cancel_early_beat%0d: rvalid=%b want 1", i, arb2ic_rvalid);
            end
        end
        @(negedge clkrst_core_clk);
        mem2arb_rvalid = 0; ic2arb_cancel = 1;
        @(negedge clkrst_core_clk);
        ic2arb_cancel = 0; ic2arb_req = 0;
        for (int i = 2; i < 4; i++) begin
            if (i > 2) @(negedge clkrst_core_clk);
            mem2arb_rvalid = 1; mem2arb_rdata = 32'hE0 + 32'(i);
            #1;
            n_checks++;
            if (arb2ic_rvalid !== 1'b0) begin
                n_fail++; $display("FAIL cancel_late_beat%0d: rvalid=%b want 0", i, arb2ic_rvalid);
            end
        end
        @(negedge clkrst_core_clk);
        mem2arb_rvalid = 0;
        #1;
        n_checks++;
        if ({arb2ic_done, arb2dc_done} !== 2'b00) begin
            n_fail++;
            $display("FAIL cancel_done: ic_done=%b dc_done=%b want 0 0", arb2ic_done, arb2dc_done);
        end
        @(negedge clkrst_core_clk);
        @(negedge clkrst_core_clk);
        mem2arb_ready = 1;
        #1;
        n_checks++;
        if ({arb2mem_valid, arb2mem_addr} !== {1'b1, 28'h0000500}) begin
            n_fail++;
            $display("FAIL cancel_dc_next: valid=%b addr=%h want 1 0000500",
                     arb2mem_valid, arb2mem_addr);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clkrst_core_clk);
            mem2arb_ready = 0; mem2arb_rvalid = 1; mem2arb_rdata = 32'hF0 + 32'(i);
            #1;
            if (arb2dc_rvalid === 1'b1) dc_beats++;
        end
        @(negedge clkrst_core_clk);
        mem2arb_rvalid = 0;
        #1;
        n_checks++;
        if ({arb2dc_done, 3'(dc_beats)} !== {1'b1, 3'd4}) begin
            n_fail++;
            $display("FAIL cancel_dc_complete: done=%b beats=%0d want 1 4", arb2dc_done, dc_beats);
        end
        clear_inputs();
        @(negedge clkrst_core_clk);
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clkrst_core_clk);
        ic2arb_req = 1; ic2arb_addr = 28'h0000600;
        @(negedge clkrst_core_clk);
        mem2arb_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clkrst_core_clk);
            mem2arb_ready = 0; mem2arb_rvalid = 1; mem2arb_rdata = 32'h60 + 32'(i);
            #1;
            n_checks++;
            if (arb2ic_rvalid !== 1'b1) begin
                n_fail++; $display("FAIL midrst_beat%0d: rvalid=%b want 1", i, arb2ic_rvalid);
            end
        end
        @(negedge clkrst_core_clk);
        mem2arb_rdata = 32'h63; clkrst_core_rst = 1;
        ic2arb_addr = 28'h0000700;
        dc2arb_req = 1; dc2arb_we = 0; dc2arb_addr = 28'h0000800;
        #1;
        n_checks++;
        if (all_out !== '0) begin
            n_fail++; $display("FAIL midrst_outputs: got %h want 0", all_out);
        end
        @(negedge clkrst_core_clk);
        mem2arb_rvalid = 0; clkrst_core_rst = 0;
        @(negedge clkrst_core_clk); #1;
        n_checks++;
        if ({arb2mem_valid, arb2mem_addr} !== {1'b1, 28'h0000700}) begin
            n_fail++;
            $display("FAIL midrst_regrant_ic: valid=%b addr=%h want 1 0000700",
                     arb2mem_valid, arb2mem_addr);
        end
        do_reset();
    endtask

    task automatic test_cmd_stall();
        logic [31:0] exp;
        @(negedge clkrst_core_clk);
        ic2arb_req = 1; ic2arb_addr = 28'h0000900;
        for (int i = 0; i < 5; i++) begin
            @(negedge clkrst_core_clk);
            mem2arb_ready = 0; mem2arb_rvalid = 1; mem2arb_rdata = 32'hDEAD_0000 + 32'(i);
            #1;
            n_checks++;
            if ({arb2mem_valid, arb2mem_addr, arb2ic_rvalid} !== {1'b1, 28'h0000900, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: valid=%b addr=%h rvalid=%b want 1 0000900 0",
                         i, arb2mem_valid, arb2mem_addr, arb2ic_rvalid);
            end
        end
        @(negedge clkrst_core_clk);
        mem2arb_rvalid = 0; mem2arb_ready = 1;
        #1;
        n_checks++;
        if (arb2mem_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_accept: valid=%b want 1", arb2mem_valid);
        end
        for (int i = 0; i < 4; i++) begin
            exp = 32'h90 + 32'(i);
            @(negedge clkrst_core_clk);
            mem2arb_ready = 0; mem2arb_rvalid = 1; mem2arb_rdata = exp;
            #1;
            n_checks++;
            if ({arb2ic_rvalid, arb2ic_rdata, arb2mem_valid} !== {1'b1, exp, 1'b0}) begin
                n_fail++;
                $display("FAIL stall_beat%0d: rvalid=%b rdata=%h valid=%b want 1 %h 0",
                         i, arb2ic_rvalid, arb2ic_rdata, arb2mem_valid, exp);
            end
        end
        @(negedge clkrst_core_clk);
        mem2arb_rvalid = 0;
        #1;
        n_checks++;
        if (arb2ic_done !== 1'b1) begin
            n_fail++; $display("FAIL stall_done: got %b want 1", arb2ic_done);
        end
        clear_inputs();
        @(negedge clkrst_core_clk);
    endtask

    initial begin
        clkrst_core_rst = 0;
        clear_inputs();
        test_reset();
        test_ic_fill();
        test_tie_round_robin();
        test_dc_writeback();
        test_ic_cancel();
        test_reset_mid_burst();
        test_cmd_stall();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
